// File: rtl/mips32_mem_pkg.sv
// Shared definitions for the MIPS32 memory responder:
// FSM state encoding and parameter defaults.
package mips32_mem_pkg;

    localparam int unsigned DEPTH_DEF = 1024;
    localparam int unsigned WAIT_DEF  = 2;
    localparam int unsigned CNT_W     = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/mips32_mem_array.sv
// Single-port synchronous word RAM; read data is registered and
// only updated on an enabled load, so it holds between accesses.
module mips32_mem_array
    import mips32_mem_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem_q[addr] <= wdata;
            end else begin
                rdata_q <= mem_q[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mips32_mem_responder.sv
// Valid/ready memory responder with a fixed number of wait states,
// out-of-range error reporting and response back-pressure.
module mips32_mem_responder
    import mips32_mem_pkg::*;
#(
    parameter int unsigned DEPTH       = DEPTH_DEF,
    parameter int unsigned WAIT_CYCLES = WAIT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic             err_q;
    logic             ld_q;

    logic             accept;
    logic             go_resp;
    logic             rsp_done;
    logic             acc_we;
    logic [31:0]      acc_addr;
    logic [31:0]      acc_wdata;
    logic             acc_oor;
    logic [31:0]      ram_rdata;

    assign req_ready = (state_q == ST_IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_done  = rsp_valid && rsp_ready;

    // With zero wait states the access happens on the accept edge,
    // before the request fields have been latched.
    assign acc_we    = (state_q == ST_IDLE) ? req_we    : we_q;
    assign acc_addr  = (state_q == ST_IDLE) ? req_addr  : addr_q;
    assign acc_wdata = (state_q == ST_IDLE) ? req_wdata : wdata_q;
    assign acc_oor   = (acc_addr >= 32'(DEPTH));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        go_resp = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_RESP;
                        go_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(WAIT_CYCLES);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_RESP;
                    cnt_d   = '0;
                    go_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            ld_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (go_resp) begin
                err_q <= acc_oor;
                ld_q  <= !acc_we && !acc_oor;
            end else if (rsp_done) begin
                err_q <= 1'b0;
                ld_q  <= 1'b0;
            end
        end
    end

    mips32_mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .en    (go_resp && !acc_oor),
        .we    (acc_we),
        .addr  (acc_addr[AW-1:0]),
        .wdata (acc_wdata),
        .rdata (ram_rdata)
    );

    assign rsp_rdata = ld_q ? ram_rdata : 32'd0;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_mips32_mem_responder.sv
// Self-checking bench: default-wait instance plus a zero-wait instance,
// directed scenarios and randomised transactions against a memory model.
module tb_mips32_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        rv = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        rr = 1'b0;

    logic        a_ready, a_valid, a_err;
    logic [31:0] a_rdata;
    logic        b_ready, b_valid, b_err;
    logic [31:0] b_rdata;

    logic        o_ready, o_valid, o_err;
    logic [31:0] o_rdata;

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] mdl_mem [16];
    bit          mdl_known [16];

    always #5 clk = ~clk;

    mips32_mem_responder #(
        .DEPTH       (1024),
        .WAIT_CYCLES (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (rv && !sel),
        .req_ready (a_ready),
        .req_we    (we),
        .req_addr  (addr),
        .req_wdata (wdata),
        .rsp_valid (a_valid),
        .rsp_ready (rr && !sel),
        .rsp_rdata (a_rdata),
        .rsp_err   (a_err)
    );

    mips32_mem_responder #(
        .DEPTH       (1024),
        .WAIT_CYCLES (0)
    ) dut0 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (rv && sel),
        .req_ready (b_ready),
        .req_we    (we),
        .req_addr  (addr),
        .req_wdata (wdata),
        .rsp_valid (b_valid),
        .rsp_ready (rr && sel),
        .rsp_rdata (b_rdata),
        .rsp_err   (b_err)
    );

    assign o_ready = sel ? b_ready : a_ready;
    assign o_valid = sel ? b_valid : a_valid;
    assign o_rdata = sel ? b_rdata : a_rdata;
    assign o_err   = sel ? b_err   : a_err;

    // Drives one request, returns the response and the number of edges
    // from the accept edge (counted as 1) to the first rsp_valid.
    task automatic do_txn(input logic twe, input logic [31:0] taddr,
                          input logic [31:0] twd, output logic [31:0] rd,
                          output logic er, output int lat);
        int n;
        @(negedge clk);
        rv = 1'b1; we = twe; addr = taddr; wdata = twd; rr = 1'b1;
        n = 0;
        while (!o_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        rv = 1'b0;
        lat = 1;
        while (!o_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = o_rdata;
        er = o_err;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_chk++; if (o_valid !== 1'b0) begin n_fail++;
            $display("FAIL rst_valid: got %b want 0", o_valid); end
        n_chk++; if (o_ready !== 1'b0) begin n_fail++;
            $display("FAIL rst_ready: got %b want 0", o_ready); end
        n_chk++; if (o_rdata !== 32'd0) begin n_fail++;
            $display("FAIL rst_rdata: got %h want 0", o_rdata); end
        n_chk++; if (o_err !== 1'b0) begin n_fail++;
            $display("FAIL rst_err: got %b want 0", o_err); end
        rst = 1'b0;
        @(posedge clk); #1;
        n_chk++; if (o_ready !== 1'b1) begin n_fail++;
            $display("FAIL rst_release_ready: got %b want 1", o_ready); end
    endtask

    task automatic test_store_load;
        logic [31:0] rd; logic er; int lat;
        do_txn(1'b1, 32'd5, 32'hDEADBEEF, rd, er, lat);
        n_chk++; if (lat !== 3) begin n_fail++;
            $display("FAIL st_latency: got %0d want 3", lat); end
        n_chk++; if (rd !== 32'd0 || er !== 1'b0) begin n_fail++;
            $display("FAIL st_rsp: got %h/%b want 0/0", rd, er); end
        n_chk++; if (o_ready !== 1'b1) begin n_fail++;
            $display("FAIL st_ready_after: got %b want 1", o_ready); end
        do_txn(1'b0, 32'd5, 32'h0, rd, er, lat);
        n_chk++; if (lat !== 3) begin n_fail++;
            $display("FAIL ld_latency: got %0d want 3", lat); end
        n_chk++; if (rd !== 32'hDEADBEEF) begin n_fail++;
            $display("FAIL ld_rdata: got %h want deadbeef", rd); end
        n_chk++; if (er !== 1'b0) begin n_fail++;
            $display("FAIL ld_err: got %b want 0", er); end
    endtask

    task automatic test_out_of_range;
        logic [31:0] rd; logic er; int lat;
        do_txn(1'b0, 32'd1024, 32'h0, rd, er, lat);
        n_chk++; if (er !== 1'b1 || rd !== 32'd0) begin n_fail++;
            $display("FAIL oor_load: got %h/%b want 0/1", rd, er); end
        n_chk++; if (lat !== 3) begin n_fail++;
            $display("FAIL oor_latency: got %0d want 3", lat); end
        do_txn(1'b1, 32'd0, 32'hA5A5_0F0F, rd, er, lat);
        do_txn(1'b1, 32'd2000, 32'h1111_2222, rd, er, lat);
        n_chk++; if (er !== 1'b1 || rd !== 32'd0) begin n_fail++;
            $display("FAIL oor_store: got %h/%b want 0/1", rd, er); end
        do_txn(1'b0, 32'd0, 32'h0, rd, er, lat);
        n_chk++; if (rd !== 32'hA5A5_0F0F || er !== 1'b0) begin n_fail++;
            $display("FAIL oor_addr0: got %h/%b want a5a50f0f/0", rd, er); end
    endtask

    task automatic test_backpressure;
        logic [31:0] rd; logic er; int lat;
        int n;
        @(negedge clk);
        rr = 1'b0; rv = 1'b1; we = 1'b0; addr = 32'd5;
        @(posedge clk); #1;
        rv = 1'b0;
        n = 0;
        while (!o_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        n_chk++; if (o_rdata !== 32'hDEADBEEF) begin n_fail++;
            $display("FAIL bp_first: got %h want deadbeef", o_rdata); end
        rv = 1'b1; we = 1'b1; addr = 32'd5; wdata = 32'h0BAD_0BAD;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_chk++;
            if (o_valid !== 1'b1 || o_rdata !== 32'hDEADBEEF ||
                o_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got v=%b d=%h r=%b want 1/deadbeef/0",
                         i, o_valid, o_rdata, o_ready);
            end
        end
        rv = 1'b0; rr = 1'b1;
        @(posedge clk); #1;
        n_chk++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin n_fail++;
            $display("FAIL bp_release: got v=%b r=%b want 0/1", o_valid, o_ready); end
        do_txn(1'b0, 32'd5, 32'h0, rd, er, lat);
        n_chk++; if (rd !== 32'hDEADBEEF) begin n_fail++;
            $display("FAIL bp_ignored_store: got %h want deadbeef", rd); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd; logic er; int lat;
        do_txn(1'b1, 32'd7, 32'h1111_1111, rd, er, lat);
        @(negedge clk);
        rv = 1'b1; we = 1'b1; addr = 32'd7; wdata = 32'h1234_5678; rr = 1'b1;
        @(posedge clk); #1;
        rv = 1'b0;
        n_chk++; if (o_ready !== 1'b0 || o_valid !== 1'b0) begin n_fail++;
            $display("FAIL rm_in_wait: got r=%b v=%b want 0/0", o_ready, o_valid); end
        rst = 1'b1;
        #1;
        n_chk++; if (o_ready !== 1'b0 || o_valid !== 1'b0) begin n_fail++;
            $display("FAIL rm_during: got r=%b v=%b want 0/0", o_ready, o_valid); end
        #1 rst = 1'b0;
        @(posedge clk); #1;
        n_chk++; if (o_ready !== 1'b1) begin n_fail++;
            $display("FAIL rm_idle: got ready %b want 1", o_ready); end
        @(posedge clk); #1;
        n_chk++; if (o_valid !== 1'b0) begin n_fail++;
            $display("FAIL rm_no_resp: got valid %b want 0", o_valid); end
        do_txn(1'b0, 32'd7, 32'h0, rd, er, lat);
        n_chk++; if (rd !== 32'h1111_1111) begin n_fail++;
            $display("FAIL rm_old_value: got %h want 11111111", rd); end
    endtask

    task automatic test_wait0;
        logic [31:0] rd; logic er; int lat;
        sel = 1'b1;
        do_txn(1'b1, 32'd3, 32'hCAFE_F00D, rd, er, lat);
        n_chk++; if (lat !== 1) begin n_fail++;
            $display("FAIL w0_st_latency: got %0d want 1", lat); end
        mdl_mem[3] = 32'hCAFE_F00D;
        mdl_known[3] = 1'b1;
        do_txn(1'b0, 32'd3, 32'h0, rd, er, lat);
        n_chk++; if (lat !== 1 || rd !== 32'hCAFE_F00D) begin n_fail++;
            $display("FAIL w0_load: got lat=%0d d=%h want 1/cafef00d", lat, rd); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd; logic er; int lat;
        logic        twe;
        logic [31:0] ta, twd, exp_d;
        logic        exp_e;
        int          bad;
        sel = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            twe = 1'($urandom_range(0, 1));
            twd = $urandom;
            if ($urandom_range(0, 9) == 0) ta = 32'd1024 + $urandom_range(0, 5000);
            else ta = 32'($urandom_range(0, 15));
            if (ta < 16 && !twe && !mdl_known[ta[3:0]]) twe = 1'b1;
            exp_e = (ta >= 1024);
            exp_d = (!twe && !exp_e) ? mdl_mem[ta[3:0]] : 32'd0;
            if (twe && !exp_e) begin
                mdl_mem[ta[3:0]] = twd;
                mdl_known[ta[3:0]] = 1'b1;
            end
            do_txn(twe, ta, twd, rd, er, lat);
            n_chk++;
            if (rd !== exp_d || er !== exp_e || lat !== 1) begin
                n_fail++;
                if (bad < 10)
                    $display("FAIL b2b[%0d] we=%b a=%h: got d=%h e=%b lat=%0d want %h/%b/1",
                             i, twe, ta, rd, er, lat, exp_d, exp_e);
                bad++;
            end
        end
        sel = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mdl_mem[i] = '0;
            mdl_known[i] = 1'b0;
        end
        test_reset();
        test_store_load();
        test_out_of_range();
        test_backpressure();
        test_reset_mid();
        test_wait0();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
